eval_select: RTL and testbench
==============================

Name: eval_select

Overview:
- Sits directly downstream of evaluate and consumes its eval / eval_valid / eval_pv_flag / insufficient_material outputs.
- Steps through a list of candidate child boards for one ply and requests each board's evaluation from upstream.
- Acknowledges each result to evaluate through clear_eval.
- Keeps the best score (white maximises, black minimises) with its move index, and stops early on a beta/alpha cutoff.

Parameters:
- EVAL_WIDTH, 24, signed evaluation width; must match evaluate.
- INDEX_WIDTH, 8, width of the move index and move count.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous reset, active-low (asserted when 0)
- start  input  1  one-cycle pulse that begins a selection; ignored unless the state is IDLE or DONE
- white_maximise  input  1  captured at start; 1 = keep the maximum, 0 = keep the minimum
- move_count  input  INDEX_WIDTH  number of candidates, captured at start
- alpha  input  EVAL_WIDTH  signed lower bound, captured at start
- beta  input  EVAL_WIDTH  signed upper bound, captured at start
- eval  input  EVAL_WIDTH  signed score from evaluate
- eval_valid  input  1  evaluate result valid; held high by evaluate until clear_eval
- eval_pv_flag  input  1  PV flag accompanying eval
- insufficient_material  input  1  accompanies eval; forces the score to 0
- eval_req  output  1  one-cycle pulse asking upstream to present board eval_index to evaluate
- eval_index  output  INDEX_WIDTH  index of the candidate currently being evaluated
- clear_eval  output  1  one-cycle acknowledge to evaluate
- busy  output  1  high in every state except IDLE and DONE
- done  output  1  high in DONE
- best_eval  output  EVAL_WIDTH  signed best score
- best_index  output  INDEX_WIDTH  index that produced best_eval
- best_pv_flag  output  1  eval_pv_flag of the best candidate
- cutoff  output  1  selection ended early on a bound
- no_moves  output  1  move_count was 0

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE; reset mid-operation aborts the selection.
  - Every output is 0: eval_req, clear_eval, busy, done, cutoff, no_moves, best_pv_flag, eval_index, best_index and best_eval.
- Constants: MAXV = 2^(EVAL_WIDTH-1)-1. The initial best is -MAXV when maximising and +MAXV when minimising. -2^(EVAL_WIDTH-1) is never used.
- States: IDLE, REQ, WAIT, ACK, SETTLE, DONE.
- IDLE/DONE, on start:
  - Capture the start inputs.
  - Set eval_index=0, best_eval to the initial best, best_index=0, best_pv_flag=0, cutoff=0.
  - If move_count==0: set no_moves=1 and go to DONE.
  - Otherwise: set no_moves=0 and go to REQ.
- REQ: eval_req=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - Wait for eval_valid, with no timeout.
  - On eval_valid, form s = insufficient_material ? 0 : eval.
  - Update the best when maximising and s > best_eval, or when minimising and s < best_eval. Strict compare: on a tie the earlier index is kept.
  - An update loads best_eval=s, best_index=eval_index and best_pv_flag=eval_pv_flag.
  - Go to ACK.
- ACK:
  - clear_eval=1 for exactly one cycle.
  - Compute the cutoff condition from the updated best_eval: maximising and best_eval >= beta, or minimising and best_eval <= alpha.
  - Go to SETTLE.
- SETTLE: one cycle in which eval_valid is ignored, covering evaluate's registered drop of eval_valid. Then, in priority order:
  - If the cutoff condition holds: set cutoff=1 and go to DONE.
  - Else if eval_index == count-1: go to DONE.
  - Else: increment eval_index and go to REQ.
- DONE: done=1; results hold until the next start. start in DONE behaves as in IDLE.
- Inputs while busy:
  - start while busy is ignored.
  - eval_valid outside WAIT is ignored.
  - Changes to alpha, beta, move_count or white_maximise after start have no effect.
- Latency per candidate, from eval_valid high in WAIT:
  - Capture at the next edge.
  - clear_eval is high 1 cycle later.
  - The next eval_req comes 2 cycles after clear_eval.
- Arithmetic:
  - All compares are signed at EVAL_WIDTH.
  - eval_index counts up to at most count-1 and never wraps. move_count = 2^INDEX_WIDTH-1 is legal.
- Simultaneous reset and start: reset wins.

Test Plan:
- Reset, then maximising with count=3, alpha=-1000, beta=1000, evals 50, 120, 120 -> best_eval=120, best_index=1 (tie keeps the earlier index), done=1, cutoff=0, exactly 3 eval_req and 3 clear_eval pulses.
- Minimising with count=4, alpha=-100, evals 30, -150, then nothing more -> after the second result best_eval=-150, best_index=1, cutoff=1, done=1, only 2 eval_req pulses.
- count=0 start -> DONE one cycle after start, no_moves=1, best_eval=-8388607 (maximising), no eval_req.
- Maximising, count=2, evals -5 with insufficient_material=1, then 3 with pv_flag=1 -> first s=0, final best_eval=3, best_index=1, best_pv_flag=1.
- Hold eval_valid high for 2 extra cycles after clear_eval with count=2 -> the stale valid is ignored, the second result is captured only after the second eval_req, and 2 clear_eval pulses occur in total.
- Drive reset low while in WAIT, then start during busy in a fresh run -> all outputs are 0 after reset, and the start during busy is ignored: eval_index is unchanged and no extra eval_req occurs.

Source files
------------

// File: rtl/eval_select_if.sv
// Request/result handshake between eval_select (master) and the evaluate side (slave).
// eval_select asks for board eval_index, evaluate answers with a held-valid result.
interface eval_select_if #(
   parameter int EVAL_WIDTH  = 24,
   parameter int INDEX_WIDTH = 8
);
   logic                          eval_req;
   logic [INDEX_WIDTH-1:0]        eval_index;
   logic                          clear_eval;
   logic signed [EVAL_WIDTH-1:0]  eval;
   logic                          eval_valid;
   logic                          eval_pv_flag;
   logic                          insufficient_material;

   modport master (
      output eval_req, eval_index, clear_eval,
      input  eval, eval_valid, eval_pv_flag, insufficient_material
   );

   modport slave (
      input  eval_req, eval_index, clear_eval,
      output eval, eval_valid, eval_pv_flag, insufficient_material
   );
endinterface

// File: rtl/eval_select.sv
// Walks the candidate boards of one ply, requesting each evaluation and keeping the
// best score (white maximises, black minimises), stopping early on an alpha/beta cutoff.
module eval_select #(
   parameter int EVAL_WIDTH  = 24,
   parameter int INDEX_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         white_maximise,
   input  logic [INDEX_WIDTH-1:0]       move_count,
   input  logic signed [EVAL_WIDTH-1:0] alpha,
   input  logic signed [EVAL_WIDTH-1:0] beta,
   eval_select_if.master                ev,
   output logic                         busy,
   output logic                         done,
   output logic signed [EVAL_WIDTH-1:0] best_eval,
   output logic [INDEX_WIDTH-1:0]       best_index,
   output logic                         best_pv_flag,
   output logic                         cutoff,
   output logic                         no_moves
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, ACK, SETTLE, DONE} state_t;

   // Symmetric range: the most negative code is never produced.
   localparam logic signed [EVAL_WIDTH-1:0] MAXV     = {1'b0, {(EVAL_WIDTH-1){1'b1}}};
   localparam logic signed [EVAL_WIDTH-1:0] NEG_MAXV = -MAXV;
   localparam logic [INDEX_WIDTH-1:0]       ONE      = 1;

   state_t                       state, state_nx;
   logic                         maximise_q;
   logic [INDEX_WIDTH-1:0]       count_q;
   logic signed [EVAL_WIDTH-1:0] alpha_q, beta_q;
   logic [INDEX_WIDTH-1:0]       index_q;
   logic                         cut_q;

   logic signed [EVAL_WIDTH-1:0] score;
   logic                         better;
   logic                         cut_cond;
   logic                         last;
   logic                         start_ok;

   assign score    = ev.insufficient_material ? '0 : ev.eval;
   assign better   = maximise_q ? (score > best_eval) : (score < best_eval);
   assign cut_cond = maximise_q ? (best_eval >= beta_q) : (best_eval <= alpha_q);
   assign last     = (index_q == count_q - ONE);
   assign start_ok = start && (state == IDLE || state == DONE);

   // NOTE: the reset here is synchronous, so it lives inside the clocked block and state uses <= only.
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      state_nx      = state;
      ev.eval_req   = 1'b0;
      ev.clear_eval = 1'b0;
      busy          = 1'b1;
      done          = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            busy = 1'b0;
            done = (state == DONE);
            if (start) state_nx = (move_count == '0) ? DONE : REQ;
         end
         REQ: begin
            ev.eval_req = 1'b1;
            state_nx    = WAIT;
         end
         WAIT:   if (ev.eval_valid) state_nx = ACK;
         ACK: begin
            ev.clear_eval = 1'b1;
            state_nx      = SETTLE;
         end
         SETTLE: begin
            // evaluate drops eval_valid one cycle after clear_eval; nothing is sampled here
            if (cut_q || last) state_nx = DONE;
            else               state_nx = REQ;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         maximise_q   <= 1'b0;
         count_q      <= '0;
         alpha_q      <= '0;
         beta_q       <= '0;
         index_q      <= '0;
         cut_q        <= 1'b0;
         best_eval    <= '0;
         best_index   <= '0;
         best_pv_flag <= 1'b0;
         cutoff       <= 1'b0;
         no_moves     <= 1'b0;
      end else begin
         if (start_ok) begin
            maximise_q   <= white_maximise;
            count_q      <= move_count;
            alpha_q      <= alpha;
            beta_q       <= beta;
            index_q      <= '0;
            cut_q        <= 1'b0;
            best_eval    <= white_maximise ? NEG_MAXV : MAXV;
            best_index   <= '0;
            best_pv_flag <= 1'b0;
            cutoff       <= 1'b0;
            no_moves     <= (move_count == '0);
         end
         if (state == WAIT && ev.eval_valid && better) begin
            best_eval    <= score;
            best_index   <= index_q;
            best_pv_flag <= ev.eval_pv_flag;
         end
         if (state == ACK) cut_q <= cut_cond;
         if (state == SETTLE) begin
            if (cut_q)      cutoff  <= 1'b1;
            else if (!last) index_q <= index_q + ONE;
         end
      end
   end

   assign ev.eval_index = index_q;

endmodule

// File: tb/tb_eval_select.sv
// Randomised bench for eval_select: an evaluate responder feeds scores, and a
// loop-level reference model predicts best score, index, PV flag, cutoff and request count.
module tb_eval_select;
   localparam int EW   = 24;
   localparam int IW   = 8;
   localparam int MAXV = (1 << (EW - 1)) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 reset, start, white_maximise;
   logic [IW-1:0]        move_count;
   logic signed [EW-1:0] alpha, beta;
   logic                 busy, done, best_pv_flag, cutoff, no_moves;
   logic signed [EW-1:0] best_eval;
   logic [IW-1:0]        best_index;

   eval_select_if #(.EVAL_WIDTH(EW), .INDEX_WIDTH(IW)) ifc ();

   eval_select #(.EVAL_WIDTH(EW), .INDEX_WIDTH(IW)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .white_maximise (white_maximise),
      .move_count     (move_count),
      .alpha          (alpha),
      .beta           (beta),
      .ev             (ifc.master),
      .busy           (busy),
      .done           (done),
      .best_eval      (best_eval),
      .best_index     (best_index),
      .best_pv_flag   (best_pv_flag),
      .cutoff         (cutoff),
      .no_moves       (no_moves)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Candidate table served by the responder
   int ev_data [256];
   bit im_data [256];
   bit pv_data [256];
   int hold_extra = 0;
   int stale_val  = 0;
   bit resp_on    = 1'b0;

   // Pulse counters and per-pulse timing checks, sampled on the falling edge
   int cycle = 0, req_total = 0, clr_total = 0, last_clr = -1;
   bit prev_req = 1'b0, prev_clr = 1'b0;
   always @(negedge clk) begin
      cycle++;
      if (ifc.eval_req) begin
         req_total++;
         check("req_single_cycle", int'(prev_req), 0);
         if (last_clr >= 0) check("clear_to_req_gap", cycle - last_clr, 2);
      end
      if (ifc.clear_eval) begin
         clr_total++;
         check("clear_single_cycle", int'(prev_clr), 0);
         last_clr = cycle;
      end
      if (!busy) last_clr = -1;
      prev_req = ifc.eval_req;
      prev_clr = ifc.clear_eval;
   end

   // evaluate stand-in: answers each request after a random delay and holds valid until acknowledged
   task automatic responder();
      int idx, w, dly;
      bit nxt;
      forever begin
         @(negedge clk);
         if (resp_on && ifc.eval_req) begin
            idx = int'(ifc.eval_index);
            nxt = 1'b1;
            while (nxt) begin
               dly = int'($urandom_range(0, 2));
               repeat (dly) @(negedge clk);
               ifc.eval                  = EW'(ev_data[idx]);
               ifc.insufficient_material = im_data[idx];
               ifc.eval_pv_flag          = pv_data[idx];
               ifc.eval_valid            = 1'b1;
               w = 0;
               do begin
                  @(negedge clk);
                  w++;
               end while (!ifc.clear_eval && w < 40);
               check("clear_seen", int'(ifc.clear_eval), 1);
               // a result that would win if it were wrongly captured while stale
               ifc.eval                  = EW'(stale_val);
               ifc.insufficient_material = 1'b0;
               nxt = 1'b0;
               repeat (1 + hold_extra) begin
                  @(negedge clk);
                  if (ifc.eval_req) begin
                     nxt = 1'b1;
                     idx = int'(ifc.eval_index);
                  end
               end
               ifc.eval_valid = 1'b0;
            end
         end
      end
   endtask

   // Reference: scan candidates in order, strict improvement, bound test after each result
   function automatic void model(input bit maxi, input int count, input int a, input int b,
                                 output int be, output int bi, output int bp,
                                 output int cut, output int n);
      int s;
      be  = maxi ? -MAXV : MAXV;
      bi  = 0;
      bp  = 0;
      cut = 0;
      n   = 0;
      for (int i = 0; i < count; i++) begin
         n++;
         s = im_data[i] ? 0 : ev_data[i];
         if (maxi ? (s > be) : (s < be)) begin
            be = s;
            bi = i;
            bp = int'(pv_data[i]);
         end
         if (maxi ? (be >= b) : (be <= a)) begin
            cut = 1;
            break;
         end
      end
   endfunction

   task automatic run(input string tag, input bit maxi, input int count,
                      input int a, input int b, input int hx);
      int be, bi, bp, cut, n, r0, c0, w;
      model(maxi, count, a, b, be, bi, bp, cut, n);
      hold_extra = hx;
      stale_val  = maxi ? MAXV : -MAXV;
      @(negedge clk);
      white_maximise = maxi;
      move_count     = IW'(count);
      alpha          = EW'(a);
      beta           = EW'(b);
      start          = 1'b1;
      r0             = req_total;
      c0             = clr_total;
      @(negedge clk);
      start = 1'b0;
      // captured at start, so scrambling these must not matter
      white_maximise = ~maxi;
      move_count     = IW'($urandom);
      alpha          = EW'($urandom);
      beta           = EW'($urandom);
      w = 0;
      while (!done && w < 5000) begin
         @(negedge clk);
         w++;
      end
      if (count == 0) check({tag, "_done_latency"}, w, 0);
      check({tag, "_done"},       int'(done), 1);
      check({tag, "_busy"},       int'(busy), 0);
      check({tag, "_best_eval"},  int'(best_eval), be);
      check({tag, "_best_index"}, int'(best_index), bi);
      check({tag, "_best_pv"},    int'(best_pv_flag), bp);
      check({tag, "_cutoff"},     int'(cutoff), cut);
      check({tag, "_no_moves"},   int'(no_moves), (count == 0) ? 1 : 0);
      check({tag, "_req_pulses"}, req_total - r0, n);
      check({tag, "_clr_pulses"}, clr_total - c0, n);
   endtask

   task automatic set_cand(input int i, input int e, input bit im, input bit pv);
      ev_data[i] = e;
      im_data[i] = im;
      pv_data[i] = pv;
   endtask

   initial begin
      int r0, a, b, cnt;
      bit mx;
      reset = 1'b0;
      start = 1'b0;
      white_maximise = 1'b0;
      move_count = '0;
      alpha = '0;
      beta = '0;
      ifc.eval = '0;
      ifc.eval_valid = 1'b0;
      ifc.eval_pv_flag = 1'b0;
      ifc.insufficient_material = 1'b0;
      for (int i = 0; i < 256; i++) set_cand(i, 0, 1'b0, 1'b0);
      fork
         responder();
      join_none

      repeat (3) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_best_eval", int'(best_eval), 0);
      check("rst_eval_req", int'(ifc.eval_req), 0);
      reset   = 1'b1;
      resp_on = 1'b1;

      // tie keeps the earlier index
      set_cand(0, 50, 0, 0); set_cand(1, 120, 0, 0); set_cand(2, 120, 0, 1);
      run("max3", 1'b1, 3, -1000, 1000, 0);

      // minimising cutoff after the second result
      set_cand(0, 30, 0, 0); set_cand(1, -150, 0, 1); set_cand(2, -900, 0, 0); set_cand(3, -900, 0, 0);
      run("min_cut", 1'b0, 4, -100, 1000, 0);

      run("empty", 1'b1, 0, -1000, 1000, 0);

      // insufficient material forces the first score to 0
      set_cand(0, -5, 1, 0); set_cand(1, 3, 0, 1);
      run("insuf", 1'b1, 2, -1000, 1000, 0);

      // equality with beta is a cutoff
      set_cand(0, 10, 0, 0); set_cand(1, 500, 0, 1); set_cand(2, 900, 0, 0);
      run("beta_eq", 1'b1, 3, -1000, 500, 0);

      // stale valid held across SETTLE and REQ
      set_cand(0, 10, 0, 0); set_cand(1, 20, 0, 0);
      run("stale", 1'b1, 2, -1000, 1000, 2);

      // reset while waiting for a result, with start asserted in the same cycle
      resp_on = 1'b0;
      @(negedge clk);
      white_maximise = 1'b1; move_count = 8'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("wait_busy", int'(busy), 1);
      reset = 1'b0;
      start = 1'b1;
      @(negedge clk);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_eval_req", int'(ifc.eval_req), 0);
      check("abort_clear_eval", int'(ifc.clear_eval), 0);
      check("abort_eval_index", int'(ifc.eval_index), 0);
      check("abort_best_eval", int'(best_eval), 0);
      check("abort_best_index", int'(best_index), 0);
      check("abort_best_pv", int'(best_pv_flag), 0);
      check("abort_cutoff", int'(cutoff), 0);
      check("abort_no_moves", int'(no_moves), 0);
      reset = 1'b1;
      start = 1'b0;
      @(negedge clk);
      check("reset_beats_start", int'(busy), 0);

      // start while busy is ignored
      white_maximise = 1'b1; move_count = 8'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      r0 = req_total;
      white_maximise = 1'b0; move_count = 8'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("busy_start_index", int'(ifc.eval_index), 0);
      check("busy_start_busy", int'(busy), 1);
      check("busy_start_no_moves", int'(no_moves), 0);
      check("busy_start_best", int'(best_eval), -MAXV);
      check("busy_start_reqs", req_total - r0, 0);
      reset = 1'b0;
      @(negedge clk);
      reset   = 1'b1;
      resp_on = 1'b1;

      // full-length list: index runs to 254 without wrapping
      for (int i = 0; i < 255; i++) set_cand(i, int'($urandom_range(0, 400)) - 200, 1'b0, 1'($urandom));
      set_cand(254, 300, 0, 1);
      run("len255", 1'b1, 255, -MAXV, MAXV, 0);

      for (int t = 0; t < 25; t++) begin
         mx  = 1'($urandom);
         cnt = int'($urandom_range(1, 8));
         for (int i = 0; i < cnt; i++)
            set_cand(i, int'($urandom_range(0, 400)) - 200, ($urandom_range(0, 7) == 0), 1'($urandom));
         a = int'($urandom_range(0, 500)) - 250;
         b = int'($urandom_range(0, 500)) - 250;
         run($sformatf("rnd%0d", t), mx, cnt, a, b, int'($urandom_range(0, 2)));
      end

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
